// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared memory-bus types for the main-memory arbiter and its grant picker.
// Bus widths, line-burst length and the arbiter state/owner encodings live here.
package ama_riscv_mem_arb_pkg;

  localparam int MEM_ADDR_BUS         = 12;
  localparam int MEM_DATA_BUS         = 128;
  localparam int MEM_TRANSFERS_PER_CL = 4;

  typedef enum logic {
    DMEM_READ  = 1'b0,
    DMEM_WRITE = 1'b1
  } dmem_rtype_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IC_RD,
    ARB_DC_RD,
    ARB_DC_WR
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_IC,
    ARB_OWN_DC
  } arb_owner_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ama_riscv_mem_arb_pick.sv
// Two-input grant picker for the memory arbiter. MEM_ARB_RR_EN selects
// round-robin on ties (with a last_grant register); default is dcache-first.
module ama_riscv_mem_arb_pick
  import ama_riscv_mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  arb_owner_t upd_owner,
`endif
  input  logic       ic_valid,
  input  logic       dc_valid,
  output arb_owner_t grant
);

`ifdef MEM_ARB_RR_EN
  arb_owner_t last_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= ARB_OWN_DC;
    end else if (upd) begin
      last_grant <= upd_owner;
    end
  end

  // On a tie the requester that did not own the previous line wins
  always_comb begin
    if (ic_valid && dc_valid) begin
      grant = (last_grant == ARB_OWN_DC) ? ARB_OWN_IC : ARB_OWN_DC;
    end else begin
      grant = ic_valid ? ARB_OWN_IC : ARB_OWN_DC;
    end
  end
`else
  assign grant = (dc_valid || !ic_valid) ? ARB_OWN_DC : ARB_OWN_IC;
`endif

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// Main-memory port arbiter between icache fills and dcache fills/writebacks.
// Grant is held for a full line burst; MEM_ARB_RR_EN enables round-robin ties.
module ama_riscv_mem_arb
  import ama_riscv_mem_arb_pkg::*;
#(
  parameter int BEATS = MEM_TRANSFERS_PER_CL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ic_req_valid,
  output logic                    ic_req_ready,
  input  logic [MEM_ADDR_BUS-1:0] ic_req_addr,
  output logic                    ic_rsp_valid,
  output logic [MEM_DATA_BUS-1:0] ic_rsp_data,
  input  logic                    dc_req_valid,
  output logic                    dc_req_ready,
  input  logic [MEM_ADDR_BUS-1:0] dc_req_addr,
  input  logic                    dc_req_rtype,
  input  logic [MEM_DATA_BUS-1:0] dc_req_wdata,
  output logic                    dc_rsp_valid,
  output logic [MEM_DATA_BUS-1:0] dc_rsp_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [MEM_ADDR_BUS-1:0] mem_req_addr,
  output logic                    mem_req_rtype,
  output logic [MEM_DATA_BUS-1:0] mem_req_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [MEM_DATA_BUS-1:0] mem_rsp_data
);

  localparam int             CNT_W    = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(BEATS - 1);
  localparam bit             BEATS_OK = is_pow2(BEATS) && (BEATS >= 2);

  arb_state_t       state;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] rsp_cnt;
  logic             req_done;
  arb_owner_t       pick_owner;
  arb_owner_t       owner;
  logic             fwd;
  logic             own_ic;
  logic             accept;
  logic             rsp_take;
  logic             burst_end;

  ama_riscv_mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .upd       (burst_end),
    .upd_owner (owner),
`endif
    .ic_valid  (ic_req_valid),
    .dc_valid  (dc_req_valid),
    .grant     (pick_owner)
  );

  // IDLE forwards the picked requester with zero latency; busy states forward only the owner
  always_comb begin
    owner = pick_owner;
    fwd   = 1'b0;
    case (state)
      ARB_IDLE:  fwd = ic_req_valid | dc_req_valid;
      ARB_IC_RD: begin
        owner = ARB_OWN_IC;
        fwd   = !req_done;
      end
      default: begin
        owner = ARB_OWN_DC;
        fwd   = !req_done;
      end
    endcase
    fwd = fwd & rst_n;
  end

  assign own_ic        = (owner == ARB_OWN_IC);
  assign mem_req_valid = fwd & (own_ic ? ic_req_valid : dc_req_valid);
  assign mem_req_addr  = !fwd ? '0 : (own_ic ? ic_req_addr : dc_req_addr);
  assign mem_req_rtype = fwd & !own_ic & dc_req_rtype;
  assign mem_req_wdata = (fwd & !own_ic) ? dc_req_wdata : '0;
  assign ic_req_ready  = fwd & own_ic & mem_req_ready;
  assign dc_req_ready  = fwd & !own_ic & mem_req_ready;
  assign accept        = mem_req_valid & mem_req_ready;

  assign ic_rsp_valid  = rst_n & mem_rsp_valid & (state == ARB_IC_RD);
  assign dc_rsp_valid  = rst_n & mem_rsp_valid & (state == ARB_DC_RD);
  assign ic_rsp_data   = ic_rsp_valid ? mem_rsp_data : '0;
  assign dc_rsp_data   = dc_rsp_valid ? mem_rsp_data : '0;
  assign rsp_take      = ic_rsp_valid | dc_rsp_valid;

  // Reads end on the last response beat, writebacks on the last accepted beat
  assign burst_end = (rsp_take && (rsp_cnt == LAST)) ||
                     ((state == ARB_DC_WR) && accept && (req_cnt == LAST));

  always_ff @(posedge clk) begin
    if (!rst_n || burst_end) begin
      state    <= ARB_IDLE;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      req_done <= 1'b0;
    end else begin
      if (accept) begin
        if (state == ARB_IDLE) begin
          req_cnt <= CNT_W'(1);
          if (own_ic) begin
            state <= ARB_IC_RD;
          end else if (dmem_rtype_t'(dc_req_rtype) == DMEM_WRITE) begin
            state <= ARB_DC_WR;
          end else begin
            state <= ARB_DC_RD;
          end
        end else begin
          req_cnt <= req_cnt + CNT_W'(1);
          if (req_cnt == LAST) begin
            req_done <= 1'b1;
          end
        end
      end
      if (rsp_take) begin
        rsp_cnt <= rsp_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (BEATS_OK);
      assert (!(mem_rsp_valid && (state == ARB_IDLE || state == ARB_DC_WR)));
    end
  end

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Directed bench for ama_riscv_mem_arb; expectations follow MEM_ARB_RR_EN if defined.
module tb_ama_riscv_mem_arb;
  import ama_riscv_mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req_valid, ic_req_ready, ic_rsp_valid;
  logic [11:0]  ic_req_addr;
  logic [127:0] ic_rsp_data;
  logic         dc_req_valid, dc_req_ready, dc_req_rtype, dc_rsp_valid;
  logic [11:0]  dc_req_addr;
  logic [127:0] dc_req_wdata, dc_rsp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_rtype, mem_rsp_valid;
  logic [11:0]  mem_req_addr;
  logic [127:0] mem_req_wdata, mem_rsp_data;

  int checks = 0;
  int errors = 0;
  arb_owner_t last_grant = ARB_OWN_DC;

  always #5 clk = ~clk;

  ama_riscv_mem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_rtype(dc_req_rtype), .dc_req_wdata(dc_req_wdata),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rtype(mem_req_rtype), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_rtype = 0; dc_req_wdata = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  // One read line burst: 4 request beats, one blocked cycle, 4 response beats
  task automatic rd_burst(input bit use_ic, input bit use_dc, input logic [11:0] base,
                          input string tag);
    arb_owner_t   exp;
    logic [11:0]  ea;
    logic [127:0] d;
    if (use_ic && use_dc)
      exp = (RR_EN && last_grant == ARB_OWN_DC) ? ARB_OWN_IC : ARB_OWN_DC;
    else
      exp = use_ic ? ARB_OWN_IC : ARB_OWN_DC;
    for (int i = 0; i < 4; i++) begin
      ic_req_valid = use_ic; dc_req_valid = use_dc; dc_req_rtype = 1'b0;
      ic_req_addr = base + 12'(i);
      dc_req_addr = base + 12'h080 + 12'(i);
      mem_req_ready = 1'b1;
      ea = (exp == ARB_OWN_IC) ? ic_req_addr : dc_req_addr;
      #1;
      chk({tag, "_mvalid"}, mem_req_valid, 1);
      chk({tag, "_maddr"}, mem_req_addr, ea);
      chk({tag, "_mrtype"}, mem_req_rtype, 0);
      chk({tag, "_icrdy"}, ic_req_ready, exp == ARB_OWN_IC);
      chk({tag, "_dcrdy"}, dc_req_ready, exp == ARB_OWN_DC);
      next_cycle();
    end
    #1;
    chk({tag, "_blk_mvalid"}, mem_req_valid, 0);
    chk({tag, "_blk_icrdy"}, ic_req_ready, 0);
    chk({tag, "_blk_dcrdy"}, dc_req_ready, 0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      d = {base, 116'(i + 1)};
      mem_rsp_valid = 1'b1; mem_rsp_data = d;
      #1;
      chk({tag, "_icrv"}, ic_rsp_valid, exp == ARB_OWN_IC);
      chk({tag, "_dcrv"}, dc_rsp_valid, exp == ARB_OWN_DC);
      chk({tag, "_rdata"}, (exp == ARB_OWN_IC) ? ic_rsp_data : dc_rsp_data, d);
      chk({tag, "_rsp_icrdy"}, ic_req_ready, 0);
      chk({tag, "_rsp_dcrdy"}, dc_req_ready, 0);
      next_cycle();
    end
    clear_inputs();
    #1;
    chk({tag, "_idle"}, dut.state == ARB_IDLE, 1);
    last_grant = exp;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    ic_req_valid = 1; ic_req_addr = 12'h123; mem_req_ready = 1;
    next_cycle();
    chk("rst_icrdy", ic_req_ready, 0);
    chk("rst_mvalid", mem_req_valid, 0);
    chk("rst_maddr", mem_req_addr, 0);
    chk("rst_icrv", ic_rsp_valid, 0);
    chk("rst_state", dut.state == ARB_IDLE, 1);
    next_cycle();
    clear_inputs();
    rst_n = 1;
    next_cycle();

    // icache only
    rd_burst(1, 0, 12'h040, "ic_only");

    // dcache writeback
    for (int i = 0; i < 4; i++) begin
      dc_req_valid = 1; dc_req_rtype = 1; mem_req_ready = 1;
      dc_req_addr = 12'h100 + 12'(i);
      dc_req_wdata = {4{32'hA5A5_0000 | 32'(i)}};
      #1;
      chk("wb_mvalid", mem_req_valid, 1);
      chk("wb_maddr", mem_req_addr, 12'h100 + 12'(i));
      chk("wb_rtype", mem_req_rtype, 1);
      chk("wb_wdata", mem_req_wdata, {4{32'hA5A5_0000 | 32'(i)}});
      chk("wb_dcrdy", dc_req_ready, 1);
      next_cycle();
    end
    clear_inputs();
    #1;
    chk("wb_idle", dut.state == ARB_IDLE, 1);
    chk("wb_norsp", dc_rsp_valid, 0);
    last_grant = ARB_OWN_DC;

    // backpressure on a writeback, icache requesting from the second cycle
    for (int c = 0; c < 7; c++) begin
      dc_req_valid = 1; dc_req_rtype = 1;
      dc_req_addr = 12'h100 + 12'(c / 2);
      dc_req_wdata = 128'(c / 2);
      ic_req_valid = (c > 0); ic_req_addr = 12'h3F0;
      mem_req_ready = (c % 2 == 0);
      #1;
      chk("bp_mvalid", mem_req_valid, 1);
      chk("bp_maddr", mem_req_addr, 12'h100 + 12'(c / 2));
      chk("bp_dcrdy", dc_req_ready, (c % 2 == 0));
      chk("bp_icrdy", ic_req_ready, 0);
      next_cycle();
    end
    clear_inputs();
    #1;
    chk("bp_idle", dut.state == ARB_IDLE, 1);
    last_grant = ARB_OWN_DC;

    // reset after two read responses
    for (int i = 0; i < 4; i++) begin
      ic_req_valid = 1; ic_req_addr = 12'h0C0 + 12'(i); mem_req_ready = 1;
      #1;
      chk("rr_icrdy", ic_req_ready, 1);
      next_cycle();
    end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1; mem_rsp_data = 128'hBEEF + 128'(i);
      #1;
      chk("rr_icrv", ic_rsp_valid, 1);
      chk("rr_rdata", ic_rsp_data, 128'hBEEF + 128'(i));
      next_cycle();
    end
    rst_n = 0;
    mem_rsp_valid = 1; mem_rsp_data = 128'hDEAD; ic_req_valid = 1; mem_req_ready = 1;
    #1;
    chk("rr_drop_rv", ic_rsp_valid, 0);
    chk("rr_drop_rdata", ic_rsp_data, 0);
    chk("rr_rst_icrdy", ic_req_ready, 0);
    chk("rr_rst_mvalid", mem_req_valid, 0);
    next_cycle();
    clear_inputs();
    rst_n = 1;
    #1;
    chk("rr_state_idle", dut.state == ARB_IDLE, 1);
    chk("rr_all_icrv", ic_rsp_valid, 0);
    chk("rr_all_dcrv", dc_rsp_valid, 0);
    last_grant = ARB_OWN_DC;

    // back-to-back collisions, then an icache-only burst
    rd_burst(1, 1, 12'h200, "coll0");
    rd_burst(1, 1, 12'h240, "coll1");
    rd_burst(1, 1, 12'h280, "coll2");
    rd_burst(1, 0, 12'h300, "ic_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
